// File: rtl/reg_writeback_buffer.sv
// In-order write-back queue in front of the register file's single write port.
// Drops writes to $0 and forwards the youngest pending data for two read ports.
module reg_writeback_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [ADDR_W-1:0]        wb_reg,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     drain_en,
    output logic                     rf_WriteEnable,
    output logic [ADDR_W-1:0]        rf_WriteReg,
    output logic [DATA_W-1:0]        rf_DstData,
    input  logic [ADDR_W-1:0]        SrcReg1,
    input  logic [ADDR_W-1:0]        SrcReg2,
    output logic                     fwd_hit1,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic                     fwd_hit2,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ent_reg  [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              push;
    logic              pop;

    // Ready depends only on registered occupancy; a same-cycle pop does not free a slot.
    assign wb_ready = (count != CNT_W'(DEPTH));
    assign push     = wb_valid & wb_ready & (wb_reg != '0);
    assign pop      = drain_en & (count != '0);

    assign rf_WriteEnable = pop;
    assign rf_WriteReg    = pop ? ent_reg[head]  : '0;
    assign rf_DstData     = pop ? ent_data[head] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_reg[i]  <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            if (push) begin
                ent_reg[tail]  <= wb_reg;
                ent_data[tail] <= wb_data;
                tail           <= tail + PTR_W'(1);
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Walk entries oldest to youngest so the last match (closest to tail) wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        idx       = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if ((SrcReg1 != '0) && (ent_reg[idx] == SrcReg1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = ent_data[idx];
                end
                if ((SrcReg2 != '0) && (ent_reg[idx] == SrcReg2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = ent_data[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Scoreboard bench for reg_writeback_buffer: a queue model predicts occupancy,
// ready, forwarding and the ordered stream of register-file writes.
module tb_reg_writeback_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_reg;
    logic [DATA_W-1:0] wb_data;
    logic              drain_en;
    logic              rf_WriteEnable;
    logic [ADDR_W-1:0] rf_WriteReg;
    logic [DATA_W-1:0] rf_DstData;
    logic [ADDR_W-1:0] SrcReg1;
    logic [ADDR_W-1:0] SrcReg2;
    logic              fwd_hit1;
    logic [DATA_W-1:0] fwd_data1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data2;
    logic [$clog2(DEPTH):0] count;

    wr_t model[$];
    wr_t exp_q[$];
    wr_t mon_e;
    int  vectors = 0;
    int  errors  = 0;

    reg_writeback_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
        .drain_en(drain_en),
        .rf_WriteEnable(rf_WriteEnable), .rf_WriteReg(rf_WriteReg), .rf_DstData(rf_DstData),
        .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
        .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Youngest pending write to s, as {hit, data}; $0 never hits.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] s);
        logic [DATA_W:0] res;
        res = '0;
        if (s != '0)
            foreach (model[i])
                if (model[i].r == s) res = {1'b1, model[i].d};
        return res;
    endfunction

    // One clock cycle: drive, check at negedge, advance the model, step past posedge.
    task automatic cycle(input logic v, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] dat,
                         input logic dr, input logic [ADDR_W-1:0] s1, input logic [ADDR_W-1:0] s2);
        logic [DATA_W:0] f1, f2;
        logic acc, pm;
        wb_valid = v; wb_reg = r; wb_data = dat; drain_en = dr; SrcReg1 = s1; SrcReg2 = s2;
        @(negedge clk);
        f1 = lookup(s1);
        f2 = lookup(s2);
        chk("wb_ready", 32'(wb_ready), 32'(model.size() != DEPTH));
        chk("count", 32'(count), 32'(model.size()));
        chk("rf_we", 32'(rf_WriteEnable), 32'(dr && model.size() != 0));
        if (!(dr && model.size() != 0))
            chk("rf_idle_bus", 32'({rf_WriteReg, rf_DstData}), 32'(0));
        chk("fwd1", 32'({fwd_hit1, fwd_data1}), 32'(f1));
        chk("fwd2", 32'({fwd_hit2, fwd_data2}), 32'(f2));
        acc = v && (model.size() != DEPTH);
        pm  = dr && (model.size() != 0);
        if (pm) void'(model.pop_front());
        if (acc && r != '0) begin
            model.push_back('{r: r, d: dat});
            exp_q.push_back('{r: r, d: dat});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
        drain_en = 1'b0; SrcReg1 = '0; SrcReg2 = '0;

        // Write monitor: every strobe must match the oldest outstanding accepted write.
        fork
            forever begin
                @(negedge clk);
                if (!rst && rf_WriteEnable) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 32'(rf_WriteReg), 32'(0));
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("wr_reg", 32'(rf_WriteReg), 32'(mon_e.r));
                        chk("wr_data", 32'(rf_DstData), 32'(mon_e.d));
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(wb_ready), 32'(1));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_we", 32'(rf_WriteEnable), 32'(0));
        rst = 1'b0;

        // Single write, lookup, drain
        cycle(1, 3, 16'h1234, 0, 3, 0);
        cycle(0, 0, 0, 0, 3, 0);
        cycle(0, 0, 0, 1, 3, 0);
        cycle(0, 0, 0, 0, 3, 0);

        // $0 writes are swallowed
        cycle(1, 0, 16'hFFFF, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);

        // Fill, stall a fifth request, then drain one slot
        for (int i = 1; i <= 4; i++) cycle(1, ADDR_W'(i), DATA_W'(16'hA000 + i), 0, ADDR_W'(i), 4);
        cycle(1, 5, 16'hA005, 0, 1, 5);
        cycle(1, 5, 16'hA005, 1, 1, 5);
        cycle(1, 5, 16'hA005, 0, 2, 5);
        repeat (6) cycle(0, 0, 0, 1, 5, 4);

        // Duplicate destination: youngest forwarded, both written in order
        cycle(1, 5, 16'h0001, 0, 0, 5);
        cycle(1, 5, 16'h0002, 0, 0, 5);
        cycle(0, 0, 0, 0, 0, 5);
        repeat (3) cycle(0, 0, 0, 1, 5, 5);

        // Streaming push+drain across pointer wrap
        for (int i = 0; i < 10; i++)
            cycle(1, ADDR_W'((i % 15) + 1), DATA_W'(16'hB000 + i), 1, ADDR_W'((i % 15) + 1), ADDR_W'(i % 15));
        repeat (2) cycle(0, 0, 0, 1, 0, 0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) cycle(1, ADDR_W'(7 + i), DATA_W'(16'hC000 + i), 0, 7, 8);
        drain_en = 1'b1; SrcReg1 = 7; SrcReg2 = 8; wb_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_count", 32'(count), 32'(0));
        chk("midrst_we", 32'(rf_WriteEnable), 32'(0));
        chk("midrst_bus", 32'({rf_WriteReg, rf_DstData}), 32'(0));
        chk("midrst_fwd", 32'({fwd_hit1, fwd_hit2, fwd_data1}), 32'(0));
        chk("midrst_ready", 32'(wb_ready), 32'(1));
        model.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cycle(0, 0, 0, 1, 7, 8);

        // Randomized traffic with small register range to provoke duplicates
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 5)), DATA_W'($urandom),
                  1'($urandom_range(0, 2) != 0), ADDR_W'($urandom_range(0, 5)), ADDR_W'($urandom_range(0, 5)));

        repeat (DEPTH + 2) cycle(0, 0, 0, 1, 0, 0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
